// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display geometry, blitter state encoding and VRAM address packing.
// Latency: n/a. Backpressure: n/a.
package chip8_pkg;

    localparam int DISP_W     = 64;
    localparam int DISP_H     = 32;
    localparam int VRAM_DEPTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RD_L,
        ST_WR_L,
        ST_RD_R,
        ST_WR_R,
        ST_CLEAR,
        ST_DONE
    } blit_state_t;

    // One byte holds eight horizontal pixels; rows are 8 bytes wide.
    function automatic logic [15:0] vram_addr_pack(input logic [4:0] y_row, input logic [2:0] xbyte);
        return {8'h00, y_row, xbyte};
    endfunction

endpackage

// File: rtl/sprite_aligner.sv
// Sprite aligner: mirrors a sprite byte into VRAM bit order and shifts it to its pixel offset.
// Latency: combinational.
// Backpressure: none.
module sprite_aligner (
    input  logic [7:0] spr_dat,
    input  logic [2:0] shift,
    output logic [7:0] mask_l,
    output logic [7:0] mask_r
);

    logic [7:0]  rev;
    logic [15:0] shifted;

    always_comb begin
        rev = '0;
        for (int i = 0; i < 8; i++) begin
            rev[i] = spr_dat[7-i];
        end
        shifted = {8'h00, rev} << shift;
        mask_l  = shifted[7:0];
        mask_r  = shifted[15:8];
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: DXYN XOR draw with collision and 00E0 clear on VRAM port A (SPRITE_WRAP_EN: edge wrap).
// Latency: 7 cycles/row aligned, 11 unaligned, clear 257; done_out one cycle after the last write.
// Backpressure: none; start pulses are accepted only in IDLE and ignored while busy.
module sprite_blitter
    import chip8_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int MEM_AW  = 12
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              draw_start_in,
    input  logic              clear_start_in,
    input  logic [7:0]        x_in,
    input  logic [7:0]        y_in,
    input  logic [3:0]        n_in,
    input  logic [MEM_AW-1:0] sprite_addr_in,
    output logic [MEM_AW-1:0] mem_addr_out,
    input  logic [7:0]        mem_data_in,
    output logic [15:0]       vram_addr_out,
    input  logic [7:0]        vram_data_in,
    output logic [7:0]        vram_data_out,
    output logic              vram_we_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              collision_out
);

    localparam logic [7:0] LAT_LAST = 8'(MEM_LAT);

    blit_state_t       state_q, state_nxt;
    logic [7:0]        cnt_q;
    logic [3:0]        row_q, n_q;
    logic [5:0]        x_q;
    logic [4:0]        y_q;
    logic [MEM_AW-1:0] base_q;
    logic [7:0]        spr_q, old_q;
    logic              coll_acc_q, coll_q;

    logic [7:0] mask_l, mask_r, wr_mask;
    logic [5:0] y_sum;
    logic [4:0] y_row;
    logic [2:0] xb_l, xb_r;
    logic       lat_hit, need_r, row_last, wr_state, hit, coll_fin;
    logic       unused_bits;

    sprite_aligner u_aligner (
        .spr_dat (spr_q),
        .shift   (x_q[2:0]),
        .mask_l  (mask_l),
        .mask_r  (mask_r)
    );

    assign unused_bits = ^{x_in[7:6], y_in[7:5], y_sum[5]};

    assign y_sum    = {1'b0, y_q} + {2'b00, row_q};
    assign y_row    = y_sum[4:0];
    assign xb_l     = x_q[5:3];
    assign xb_r     = xb_l + 3'd1;
    assign lat_hit  = (cnt_q == LAT_LAST);
    assign wr_state = (state_q == ST_WR_L) || (state_q == ST_WR_R);
    assign wr_mask  = (state_q == ST_WR_R) ? mask_r : mask_l;
    assign hit      = |(old_q & wr_mask);
    assign coll_fin = wr_state ? (coll_acc_q | hit) : 1'b0;

`ifdef SPRITE_WRAP_EN
    assign need_r   = (x_q[2:0] != 3'd0);
    assign row_last = (({1'b0, row_q} + 5'd1) == {1'b0, n_q});
`else
    // Right byte would fall off screen at xbyte 7; rows stop at the bottom edge.
    assign need_r   = (x_q[2:0] != 3'd0) && (xb_l != 3'd7);
    assign row_last = (({1'b0, row_q} + 5'd1) == {1'b0, n_q}) || (y_sum >= 6'(DISP_H - 1));
`endif

    always_comb begin
        state_nxt     = state_q;
        mem_addr_out  = '0;
        vram_addr_out = '0;
        vram_data_out = '0;
        vram_we_out   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start_in) begin
                    state_nxt = ST_CLEAR;
                end else if (draw_start_in) begin
                    state_nxt = (n_in == 4'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_addr_out = base_q + MEM_AW'(row_q);
                if (lat_hit) state_nxt = ST_RD_L;
            end
            ST_RD_L: begin
                vram_addr_out = vram_addr_pack(y_row, xb_l);
                if (lat_hit) state_nxt = ST_WR_L;
            end
            ST_WR_L: begin
                vram_addr_out = vram_addr_pack(y_row, xb_l);
                vram_data_out = old_q ^ mask_l;
                vram_we_out   = 1'b1;
                if (need_r)        state_nxt = ST_RD_R;
                else if (row_last) state_nxt = ST_DONE;
                else               state_nxt = ST_FETCH;
            end
            ST_RD_R: begin
                vram_addr_out = vram_addr_pack(y_row, xb_r);
                if (lat_hit) state_nxt = ST_WR_R;
            end
            ST_WR_R: begin
                vram_addr_out = vram_addr_pack(y_row, xb_r);
                vram_data_out = old_q ^ mask_r;
                vram_we_out   = 1'b1;
                state_nxt     = row_last ? ST_DONE : ST_FETCH;
            end
            ST_CLEAR: begin
                vram_addr_out = {8'h00, cnt_q};
                vram_we_out   = 1'b1;
                if (cnt_q == 8'(VRAM_DEPTH - 1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy_out      = (state_q != ST_IDLE);
    assign done_out      = (state_q == ST_DONE);
    assign collision_out = coll_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            n_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            base_q     <= '0;
            spr_q      <= '0;
            old_q      <= '0;
            coll_acc_q <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            // Shared phase counter: memory wait slots, and the address during clear.
            cnt_q   <= (state_nxt != state_q) ? 8'd0 : cnt_q + 8'd1;
            if (state_q == ST_IDLE) begin
                coll_acc_q <= 1'b0;
                row_q      <= '0;
                if (draw_start_in && !clear_start_in) begin
                    x_q    <= x_in[5:0];
                    y_q    <= y_in[4:0];
                    n_q    <= n_in;
                    base_q <= sprite_addr_in;
                end
            end
            if (state_q == ST_FETCH && lat_hit) spr_q <= mem_data_in;
            if ((state_q == ST_RD_L || state_q == ST_RD_R) && lat_hit) old_q <= vram_data_in;
            if (wr_state) coll_acc_q <= coll_acc_q | hit;
            if (wr_state && state_nxt == ST_FETCH) row_q <= row_q + 4'd1;
            if (state_nxt == ST_DONE && state_q != ST_DONE) coll_q <= coll_fin;
        end
    end

endmodule
